// File: rtl/status_rgb_led.sv
// status_rgb_led: RGB status LED driver showing lives, hit/bonus flashes and game-over blink
module status_rgb_led #(
  parameter int LED_W      = 4,
  parameter int HOLD_CYC   = 5000000,
  parameter int BLINK_HALF = 1250000,
  parameter int CNT_W      = 32,
  parameter int LIFE_W     = 3,
  parameter int LOW_LIFE   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hit,
  input  logic              bonus,
  input  logic              game_over,
  input  logic [LIFE_W-1:0] lives,
  output logic [LED_W-1:0]  GREEN,
  output logic [LED_W-1:0]  RED,
  output logic [LED_W-1:0]  BLUE,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, HIT, BONUS, OVER} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d, blink_q, blink_d, blink_nx;
  logic phase_q, phase_d, hold_done, blink_tc, low_life;
  logic [LED_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic busy_q, busy_d;
  assign hold_done = hold_q == CNT_W'(HOLD_CYC - 1);
  assign blink_tc  = (BLINK_HALF != 0) && (blink_q == CNT_W'(BLINK_HALF - 1));
  assign blink_nx  = (BLINK_HALF == 0 || blink_tc) ? '0 : blink_q + CNT_W'(1);
  assign low_life  = (lives != '0) && (lives <= LIFE_W'(LOW_LIFE));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      blink_q <= '0;
      phase_q <= 1'b1;
      red_q   <= '0;
      green_q <= '1;
      blue_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    blink_d = '0;
    phase_d = 1'b1;
    if (game_over && state_q != OVER) begin
      state_d = OVER;
    end else if (state_q == OVER) begin
      blink_d = blink_nx;
      phase_d = phase_q ^ blink_tc;
    end else if (hit) begin
      state_d = HIT;
    end else if (bonus && state_q != HIT) begin
      state_d = BONUS;
    end else if (state_q != IDLE) begin
      state_d = hold_done ? IDLE : state_q;
      hold_d  = hold_done ? '0 : hold_q + CNT_W'(1);
      blink_d = hold_done ? '0 : blink_nx;
      phase_d = hold_done | (phase_q ^ blink_tc);
    end
  end
  always_comb begin
    red_d   = (state_d == HIT || state_d == OVER) ? {LED_W{phase_d}} :
              (state_d == IDLE && low_life) ? '1 : '0;
    green_d = (state_d == IDLE && lives != '0) ? '1 : '0;
    blue_d  = (state_d == BONUS) ? '1 : '0;
    busy_d  = state_d != IDLE;
  end
  assign RED   = red_q;
  assign GREEN = green_q;
  assign BLUE  = blue_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_status_rgb_led.sv
// tb_status_rgb_led: directed self-checking bench for status_rgb_led
module tb_status_rgb_led;
  logic clk = 1'b0, rst = 1'b1, hit = 1'b0, bonus = 1'b0, game_over = 1'b0;
  logic [2:0] lives = 3'd3;
  logic [3:0] green, red, blue;
  logic busy;
  int checks = 0, failures = 0;
  localparam logic [12:0] GRN  = {4'h0, 4'hF, 4'h0, 1'b0};
  localparam logic [12:0] YEL  = {4'hF, 4'hF, 4'h0, 1'b0};
  localparam logic [12:0] OFF  = 13'h0;
  localparam logic [12:0] REDB = {4'hF, 4'h0, 4'h0, 1'b1};
  localparam logic [12:0] DARK = {4'h0, 4'h0, 4'h0, 1'b1};
  localparam logic [12:0] BLU  = {4'h0, 4'h0, 4'hF, 1'b1};
  status_rgb_led #(.LED_W(4), .HOLD_CYC(20), .BLINK_HALF(4), .CNT_W(32), .LIFE_W(3), .LOW_LIFE(1)) dut (
    .clk(clk), .rst(rst), .hit(hit), .bonus(bonus), .game_over(game_over), .lives(lives),
    .GREEN(green), .RED(red), .BLUE(blue), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [12:0] blink(input int i);
    return ((i / 4) % 2 == 0) ? REDB : DARK;
  endfunction
  task automatic check(input string tag, input logic [12:0] exp);
    logic [12:0] got;
    got = {red, green, blue, busy};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step;
    step;
    check("reset", GRN);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step;
      check("idle_green", GRN);
    end
    lives = 3'd1;
    step;
    check("idle_yellow", YEL);
    lives = 3'd0;
    step;
    check("idle_off", OFF);
    lives = 3'd3;
    step;
    check("idle_back", GRN);
    hit = 1'b1;
    step;
    hit = 1'b0;
    check("hit_start", REDB);
    for (int i = 1; i < 20; i++) begin
      step;
      check("hit_blink", blink(i));
    end
    step;
    check("hit_end", GRN);
    hit = 1'b1;
    step;
    hit = 1'b0;
    check("retrig_start", REDB);
    for (int i = 1; i < 10; i++) begin
      step;
      check("retrig_pre", blink(i));
    end
    hit = 1'b1;
    step;
    hit = 1'b0;
    check("retrig_again", REDB);
    for (int i = 1; i < 20; i++) begin
      step;
      check("retrig_post", blink(i));
    end
    step;
    check("retrig_end", GRN);
    bonus = 1'b1;
    step;
    bonus = 1'b0;
    check("bonus_start", BLU);
    for (int i = 1; i < 5; i++) begin
      step;
      check("bonus_hold", BLU);
    end
    hit = 1'b1;
    step;
    hit = 1'b0;
    check("preempt", REDB);
    for (int i = 1; i < 20; i++) begin
      bonus = (i == 3);
      step;
      check("preempt_blink", blink(i));
    end
    bonus = 1'b0;
    step;
    check("preempt_end", GRN);
    hit = 1'b1;
    step;
    hit = 1'b0;
    for (int i = 1; i < 4; i++) step;
    game_over = 1'b1;
    step;
    check("over_enter", REDB);
    for (int i = 1; i < 200; i++) begin
      if (i == 50) game_over = 1'b0;
      hit = (i % 7 == 0);
      bonus = (i % 11 == 0);
      lives = 3'(i % 5);
      step;
      check("over_blink", blink(i));
    end
    hit = 1'b0;
    bonus = 1'b0;
    lives = 3'd3;
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("over_reset", GRN);
    hit = 1'b1;
    rst = 1'b1;
    step;
    hit = 1'b0;
    rst = 1'b0;
    check("hit_rst", GRN);
    step;
    check("hit_rst_after", GRN);
    hit = 1'b1;
    bonus = 1'b1;
    step;
    hit = 1'b0;
    bonus = 1'b0;
    check("hit_bonus", REDB);
    for (int i = 1; i < 20; i++) begin
      step;
      check("hit_bonus_blink", blink(i));
    end
    step;
    check("hit_bonus_end", GRN);
    lives = 3'd1;
    bonus = 1'b1;
    step;
    bonus = 1'b0;
    for (int i = 1; i < 20; i++) begin
      step;
      check("bonus_full", BLU);
    end
    step;
    check("bonus_end_yellow", YEL);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
